vpu_alu_mul_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one unsigned integer multiplier (VPU_ALU_UI_MUL) between NUM_REQ requesters inside the VPU ALU. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, registers the operands, drives the shared multiplier, and returns the truncated product tagged with the requester index on a single valid/ready response port to VPU_DST_PORT.

---
 rtl/vpu_pkg.sv | 27 ++
 rtl/vpu_alu_ui_mul.sv | 29 ++
 rtl/vpu_rr_arbiter.sv | 45 ++++
 rtl/vpu_alu_mul_arb.sv | 127 ++++++++++++
 tb/tb_vpu_alu_mul_arb.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : VPU_PKG
//  Purpose  : Shared VPU constants and types.
//             OPERAND_WIDTH    - integer operand width (W)
//             MUL_ARB_NUM_REQ  - requester count of the shared multiplier
//             mul_req_t        - one operand pair {op0, op1}
//             mul_arb_id_w()   - requester index width (at least 1 bit)
//  Revision : 1.0 - initial release
// ============================================================================
package VPU_PKG;

   localparam int OPERAND_WIDTH   = 32;
   localparam int MUL_ARB_NUM_REQ = 4;

   typedef struct packed {
      logic [OPERAND_WIDTH-1:0] op0;
      logic [OPERAND_WIDTH-1:0] op1;
   } mul_req_t;

   // A single requester still needs a 1-bit index field.
   function automatic int mul_arb_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_alu_ui_mul.sv
`default_nettype none
// ============================================================================
//  Module   : VPU_ALU_UI_MUL
//  Purpose  : Unsigned integer multiplier; keeps the low WIDTH bits of the
//             product. The output is forced to zero when en is low.
//  Ports    : op_0, op_1 (in, WIDTH) operands
//             en         (in, 1)     operand pair is valid
//             result     (out, WIDTH) (op_0 * op_1) mod 2^WIDTH
//  Revision : 1.0 - initial release
// ============================================================================
module VPU_ALU_UI_MUL
   import VPU_PKG::*;
#(
   parameter int WIDTH = OPERAND_WIDTH
) (
   input  logic [WIDTH-1:0] op_0,
   input  logic [WIDTH-1:0] op_1,
   input  logic             en,
   output logic [WIDTH-1:0] result
);

   // Product sized to the operand width, so overflow truncates naturally.
   logic [WIDTH-1:0] w_prod;

   assign w_prod = op_0 * op_1;
   assign result = en ? w_prod : '0;

endmodule
`default_nettype wire

// File: rtl/vpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vpu_rr_arbiter
//  Purpose  : Combinational round-robin grant. The first asserted request
//             at or after ptr, wrapping modulo NUM_REQ, wins.
//  Ports    : req       (in, NUM_REQ)  request vector
//             ptr       (in, ID_W)     highest-priority index (< NUM_REQ)
//             grant     (out, NUM_REQ) one-hot grant, zero when no request
//             grant_idx (out, ID_W)    index of the granted request
//  Revision : 1.0 - initial release
// ============================================================================
module vpu_rr_arbiter
   import VPU_PKG::*;
#(
   parameter int NUM_REQ = MUL_ARB_NUM_REQ,
   parameter int ID_W    = mul_arb_id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   // Scan from the farthest offset back to ptr, so the last hit written is
   // the nearest request at or after the pointer.
   always_comb begin
      int v_idx;
      grant     = '0;
      grant_idx = '0;
      v_idx     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         v_idx = int'(ptr) + k;
         if (v_idx >= NUM_REQ) begin
            v_idx = v_idx - NUM_REQ;
         end
         if (req[v_idx]) begin
            grant        = '0;
            grant[v_idx] = 1'b1;
            grant_idx    = ID_W'(v_idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vpu_alu_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module   : vpu_alu_mul_arb
//  Purpose  : Round-robin arbitration of NUM_REQ requesters onto one shared
//             unsigned multiplier through a two-stage pipeline
//             (S1 = operands, S2 = product). Responses carry the requester id.
//  Ports    : clk, rst_n              clock, async active-low reset
//             req_valid_i [NUM_REQ]   per-requester valid
//             req_op0_i   [NUM_REQ*W] per-requester operand 0 (flattened)
//             req_op1_i   [NUM_REQ*W] per-requester operand 1 (flattened)
//             req_ready_o [NUM_REQ]   per-requester accept (at most one hot)
//             rsp_valid_o, rsp_id_o, rsp_result_o, rsp_ready_i  response
//             busy_o                  either stage holds a transaction
//  Revision : 1.0 - initial release
// ============================================================================
module vpu_alu_mul_arb
   import VPU_PKG::*;
#(
   parameter int NUM_REQ = MUL_ARB_NUM_REQ,
   parameter int ID_W    = mul_arb_id_w(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_op0_i,
   input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_op1_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic                           rsp_valid_o,
   output logic [ID_W-1:0]                rsp_id_o,
   output logic [OPERAND_WIDTH-1:0]       rsp_result_o,
   input  logic                           rsp_ready_i,
   output logic                           busy_o
);

   localparam int              c_w        = OPERAND_WIDTH;
   localparam logic [ID_W-1:0] c_last_idx = ID_W'(NUM_REQ - 1);

   mul_req_t               w_req [NUM_REQ];
   logic [NUM_REQ-1:0]     w_grant;
   logic [ID_W-1:0]        w_grant_idx;
   logic                   w_xfer;
   logic                   w_s1_adv;
   logic                   w_s2_adv;
   logic [c_w-1:0]         w_mul_result;

   logic [ID_W-1:0]        r_rr_ptr;
   logic                   r_s1_valid;
   mul_req_t               r_s1_req;
   logic [ID_W-1:0]        r_s1_id;
   logic                   r_s2_valid;
   logic [c_w-1:0]         r_s2_result;
   logic [ID_W-1:0]        r_s2_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_req[gi].op0 = req_op0_i[gi*c_w +: c_w];
         assign w_req[gi].op1 = req_op1_i[gi*c_w +: c_w];
      end
   endgenerate

   vpu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid_i),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   // Each stage may take a new entry when empty or when its content leaves
   // on the same edge; this gives full throughput with no bubble.
   assign w_s2_adv    = !r_s2_valid || rsp_ready_i;
   assign w_s1_adv    = !r_s1_valid || w_s2_adv;
   assign req_ready_o = w_grant & {NUM_REQ{w_s1_adv}};
   // The grant is a subset of req_valid_i, so any ready bit is a transfer.
   assign w_xfer      = |req_ready_o;

   VPU_ALU_UI_MUL #(
      .WIDTH (c_w)
   ) u_mul (
      .op_0   (r_s1_req.op0),
      .op_1   (r_s1_req.op1),
      .en     (r_s1_valid),
      .result (w_mul_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_req    <= '0;
         r_s1_id     <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_id     <= '0;
      end else begin
         if (w_xfer) begin
            r_rr_ptr <= (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + 1'b1;
         end

         if (w_s1_adv) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
               r_s1_req <= w_req[w_grant_idx];
               r_s1_id  <= w_grant_idx;
            end
         end

         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_result <= w_mul_result;
               r_s2_id     <= r_s1_id;
            end
         end
      end
   end

   assign rsp_valid_o  = r_s2_valid;
   assign rsp_id_o     = r_s2_id;
   assign rsp_result_o = r_s2_result;
   assign busy_o       = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_vpu_alu_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vpu_alu_mul_arb
//  Purpose  : Directed self-checking bench for vpu_alu_mul_arb (NUM_REQ=4,
//             W=32). Inputs change and outputs are compared 1 ns after each
//             rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vpu_alu_mul_arb;
   import VPU_PKG::*;

   localparam int NR = 4;
   localparam int W  = OPERAND_WIDTH;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid_i;
   logic [NR*W-1:0]   req_op0_i;
   logic [NR*W-1:0]   req_op1_i;
   logic [NR-1:0]     req_ready_o;
   logic              rsp_valid_o;
   logic [1:0]        rsp_id_o;
   logic [W-1:0]      rsp_result_o;
   logic              rsp_ready_i;
   logic              busy_o;

   int n_checks;
   int n_fail;

   vpu_alu_mul_arb #(.NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_op0_i    (req_op0_i),
      .req_op1_i    (req_op1_i),
      .req_ready_o  (req_ready_o),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_id_o     (rsp_id_o),
      .rsp_result_o (rsp_result_o),
      .rsp_ready_i  (rsp_ready_i),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      req_op0_i[idx*W +: W] = a;
      req_op1_i[idx*W +: W] = b;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      req_valid_i = '0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      req_valid_i = '0;
      req_op0_i   = '0;
      req_op1_i   = '0;
      rsp_ready_i = 1'b1;
      tick();
      tick();

      // ---------------- reset state ----------------
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp_id", 64'(rsp_id_o), 64'd0);
      check("rst_rsp_result", 64'(rsp_result_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_ready", 64'(req_ready_o), 64'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- single request ----------------
      set_op(2, 32'd7, 32'd6);
      req_valid_i = 4'b0100;
      #1;
      check("single_ready", 64'(req_ready_o), 64'b0100);
      tick();
      req_valid_i = '0;
      check("single_busy_c1", 64'(busy_o), 64'd1);
      check("single_rspv_c1", 64'(rsp_valid_o), 64'd0);
      tick();
      check("single_rspv_c2", 64'(rsp_valid_o), 64'd1);
      check("single_id", 64'(rsp_id_o), 64'd2);
      check("single_result", 64'(rsp_result_o), 64'd42);
      check("single_busy_c2", 64'(busy_o), 64'd1);
      tick();
      check("single_rspv_done", 64'(rsp_valid_o), 64'd0);
      check("single_busy_done", 64'(busy_o), 64'd0);

      // ---------------- fairness ----------------
      do_reset();
      for (int i = 0; i < NR; i++) set_op(i, 32'(i + 1), 32'd10);
      req_valid_i = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("fair_ready_%0d", k), 64'(req_ready_o), 64'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            check($sformatf("fair_rspv_%0d", k), 64'(rsp_valid_o), 64'd1);
            check($sformatf("fair_id_%0d", k), 64'(rsp_id_o), 64'((k - 2) % 4));
            check($sformatf("fair_res_%0d", k), 64'(rsp_result_o), 64'((((k - 2) % 4) + 1) * 10));
         end
         tick();
      end
      req_valid_i = '0;
      tick();
      tick();
      check("fair_drained", 64'(busy_o), 64'd0);

      // ---------------- overflow (pointer is now 2) ----------------
      set_op(2, 32'hFFFF_FFFF, 32'd2);
      req_valid_i = 4'b0100;
      #1;
      check("ovf_ready", 64'(req_ready_o), 64'b0100);
      tick();
      req_valid_i = '0;
      tick();
      check("ovf_rspv", 64'(rsp_valid_o), 64'd1);
      check("ovf_result", 64'(rsp_result_o), 64'hFFFF_FFFE);
      tick();

      // ---------------- back-pressure (pointer is now 3) ----------------
      rsp_ready_i = 1'b0;
      set_op(0, 32'd3, 32'd4);
      req_valid_i = 4'b0001;
      #1;
      check("bp_ready_a", 64'(req_ready_o), 64'b0001);
      tick();
      set_op(0, 32'd5, 32'd5);
      #1;
      check("bp_ready_b", 64'(req_ready_o), 64'b0001);
      tick();
      set_op(0, 32'd6, 32'd7);
      #1;
      check("bp_ready_full", 64'(req_ready_o), 64'b0000);
      check("bp_rspv", 64'(rsp_valid_o), 64'd1);
      check("bp_res_a", 64'(rsp_result_o), 64'd12);
      tick();
      check("bp_ready_still0", 64'(req_ready_o), 64'b0000);
      check("bp_hold_res", 64'(rsp_result_o), 64'd12);
      check("bp_hold_id", 64'(rsp_id_o), 64'd0);
      check("bp_hold_busy", 64'(busy_o), 64'd1);
      rsp_ready_i = 1'b1;
      #1;
      check("bp_ready_resume", 64'(req_ready_o), 64'b0001);
      tick();
      req_valid_i = '0;
      check("bp_res_b", 64'(rsp_result_o), 64'd25);
      check("bp_rspv_b", 64'(rsp_valid_o), 64'd1);
      tick();
      check("bp_res_c", 64'(rsp_result_o), 64'd42);
      check("bp_rspv_c", 64'(rsp_valid_o), 64'd1);
      tick();
      check("bp_rspv_end", 64'(rsp_valid_o), 64'd0);
      check("bp_busy_end", 64'(busy_o), 64'd0);

      // ---------------- pointer skip ----------------
      do_reset();
      req_valid_i = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("skip_ready_%0d", k), 64'(req_ready_o), (k % 2 == 0) ? 64'b0010 : 64'b1000);
         tick();
      end
      req_valid_i = '0;
      tick();
      tick();

      // ---------------- reset mid-operation ----------------
      rsp_ready_i = 1'b0;
      set_op(0, 32'd2, 32'd3);
      req_valid_i = 4'b0001;
      tick();
      tick();
      check("mid_busy_full", 64'(busy_o), 64'd1);
      check("mid_rspv_full", 64'(rsp_valid_o), 64'd1);
      req_valid_i = '0;
      rst_n = 1'b0;
      #1;
      check("mid_rspv_rst", 64'(rsp_valid_o), 64'd0);
      check("mid_busy_rst", 64'(busy_o), 64'd0);
      tick();
      rst_n       = 1'b1;
      rsp_ready_i = 1'b1;
      req_valid_i = 4'b1111;
      #1;
      check("mid_ptr_zero", 64'(req_ready_o), 64'b0001);
      tick();
      req_valid_i = '0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
